port_drain: RTL and testbench
=============================

Name: port_drain

Overview:
- Egress-side reader for one switch output port: drains the port FIFO through its read interface (port_rdy / port_rd / port_out).
- Forwards the drained bytes downstream on a valid/ready stream.
- Delimits frames by idle gaps on the port and reports each frame's byte length.
- Sits between a switch port's output interface and the downstream consumer: MAC model, checker, or the next pipeline stage.

Parameters:
- W_WIDTH, 8: data word width; must match the port FIFO word width.
- GAP_CYCLES, 4: idle cycles (port empty, no read in flight) that close a frame; must be 1 or more.
- CNT_WIDTH, 16: width of the frame-length and total byte counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- port_rdy  input  1  port FIFO non-empty.
- port_out  input  W_WIDTH  port FIFO read data; valid the cycle after port_rd is sampled high.
- port_rd  output  1  port FIFO read strobe, one word per cycle high.
- out_data  output  W_WIDTH  downstream data (head of the output buffer).
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- frame_done  output  1  one-cycle pulse: a frame has closed.
- frame_len  output  CNT_WIDTH  byte count of the closed frame; held until the next frame_done.
- byte_cnt  output  CNT_WIDTH  total bytes captured since reset; wraps.

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0, buffer empty, rd_pending 0, FSM in IDLE, all counters 0.
- FIFO read latency is fixed at 1: rd_pending <= port_rd; when rd_pending is 1, port_out is written into the output buffer (a "capture").
- Output buffer: 2-entry in-order FIFO, occupancy occ from 0 to 2.
  - out_valid = (occ != 0); out_data = head entry.
  - pop = out_valid && out_ready.
- Read issue (combinational): port_rd = port_rdy && (occ + rd_pending - pop) < 2.
  - This guarantees the buffer never overflows.
  - Sustains 1 byte per cycle when out_ready is held high.
- Capture and pop in the same cycle: occupancy unchanged; order is preserved.
- Capture into an empty buffer: out_valid rises the next cycle. End-to-end latency is port_rd to out_valid = 2 cycles.
- out_ready low: out_data and out_valid are held stable; port_rd stops once credits are exhausted.
- byte_cnt increments by 1 on every capture and wraps to 0 after all-ones.
- Frame FSM (frame accumulator acc, gap counter gap):
  - IDLE: acc=0, gap=0. On capture: acc=1 and move to ACTIVE.
  - ACTIVE:
    - capture: acc += 1 (saturates at all-ones), gap=0.
    - else if port_rdy=1 or rd_pending=1: gap=0, because backpressure does not end a frame.
    - else: gap += 1.
    - When gap would reach GAP_CYCLES: move to DONE.
  - DONE (1 cycle): frame_done=1, frame_len=acc.
    - With a capture this cycle: acc=1, go to ACTIVE.
    - Otherwise: acc=0, go to IDLE.
- frame_len is registered and updates only on entry to DONE. frame_done is registered and high for exactly one cycle.
- A capture that lands in the same cycle as gap expiry counts toward the current frame: gap clears and the FSM stays in ACTIVE.
- Reset mid-frame: the partial frame is discarded with no frame_done, buffered bytes are lost, and port_rd drops immediately.

Test Plan:
- Reset check: assert rst_n=0 asynchronously mid-cycle -> port_rd, out_valid, frame_done, frame_len, byte_cnt all 0 immediately.
- Streaming: FIFO preloaded with 0x11..0x15, out_ready=1 -> port_rd high 5 consecutive cycles; out_data 0x11..0x15 on consecutive cycles starting 2 cycles after the first port_rd; byte_cnt=5.
- Framing: frame of 5 bytes, then port empty -> frame_done pulses exactly once, GAP_CYCLES=4 cycles after the last capture, with frame_len=5.
- Backpressure: out_ready=0 with 10 bytes queued -> exactly 2 port_rd pulses, occ=2, out_data=first byte held. Then raise out_ready -> all 10 bytes delivered in order, no loss or duplication, frame_len=10, one frame_done.
- Gap boundary: port goes empty for 3 cycles mid-frame with GAP_CYCLES=4 -> no frame_done, single frame reported. An empty interval of 4 cycles -> two frames reported, with correct lengths.
- Reset mid-frame: 3 bytes captured, then reset pulse, then a new 2-byte frame -> only one frame_done, with frame_len=2 and byte_cnt=2.

Source files
------------

// File: rtl/port_drain_if.sv
// Signal bundle for port_drain: port FIFO read side, downstream valid/ready
// stream, and frame/byte reporting. master = the drain, slave = its environment.
interface port_drain_if #(
  parameter int W_WIDTH   = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 port_rdy;
  logic [W_WIDTH-1:0]   port_out;
  logic                 port_rd;
  logic [W_WIDTH-1:0]   out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 frame_done;
  logic [CNT_WIDTH-1:0] frame_len;
  logic [CNT_WIDTH-1:0] byte_cnt;

  modport master (
    input  port_rdy, port_out, out_ready,
    output port_rd, out_data, out_valid, frame_done, frame_len, byte_cnt
  );

  modport slave (
    output port_rdy, port_out, out_ready,
    input  port_rd, out_data, out_valid, frame_done, frame_len, byte_cnt
  );
endinterface

// File: rtl/port_drain.sv
// Egress reader for one switch port: drains the port FIFO into a 2-entry
// output buffer, streams it downstream, and delimits frames by idle gaps.
module port_drain #(
  parameter int W_WIDTH    = 8,
  parameter int GAP_CYCLES = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  port_drain_if.master bus
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Read issue and capture
  // ---------------------------------------------------------------------------
  logic               rd_issue;
  logic               rd_pending;
  logic               capture;
  logic               pop;
  logic               out_valid;
  logic [1:0]         occ;
  logic [2:0]         committed;

  assign capture   = rd_pending;
  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid && bus.out_ready;

  // Words held plus the one in flight, less the one leaving this cycle,
  // must stay below the buffer depth for another read to be safe.
  assign committed = {1'b0, occ} + {2'b0, rd_pending} - {2'b0, pop};
  assign rd_issue  = rst_n && bus.port_rdy && (committed < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state is always written with <= so every flop samples
    // pre-edge values regardless of process ordering.
    if (!rst_n) begin
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= rd_issue;
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry in-order output buffer
  // ---------------------------------------------------------------------------
  logic [W_WIDTH-1:0] buf_mem [2];
  logic               wr_ptr;
  logic               rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset too because the head entry drives out_data
      // directly and must read 0 out of reset.
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ        <= 2'd0;
    end else begin
      if (capture) begin
        buf_mem[wr_ptr] <= bus.port_out;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, capture} - {1'b0, pop};
    end
  end

  // ---------------------------------------------------------------------------
  // Total byte counter (wraps)
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] byte_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
    end else if (capture) begin
      byte_cnt_q <= byte_cnt_q + CNT_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] acc, acc_nxt;
  logic [GAP_W-1:0]     gap, gap_nxt, gap_inc;
  logic                 frame_done_q, done_nxt;
  logic [CNT_WIDTH-1:0] frame_len_q, len_nxt;

  assign gap_inc = gap + GAP_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      acc          <= '0;
      gap          <= '0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
    end else begin
      state        <= state_nxt;
      acc          <= acc_nxt;
      gap          <= gap_nxt;
      frame_done_q <= done_nxt;
      frame_len_q  <= len_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    acc_nxt   = acc;
    gap_nxt   = gap;
    done_nxt  = 1'b0;
    len_nxt   = frame_len_q;

    unique case (state)
      S_IDLE: begin
        acc_nxt = '0;
        gap_nxt = '0;
        if (capture) begin
          acc_nxt   = CNT_WIDTH'(1);
          state_nxt = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        if (capture) begin
          // A capture wins over gap expiry: the byte belongs to this frame.
          if (acc != '1) begin
            acc_nxt = acc + CNT_WIDTH'(1);
          end
          gap_nxt = '0;
        end else if (bus.port_rdy) begin
          // Data waiting behind backpressure keeps the frame open.
          gap_nxt = '0;
        end else if (gap_inc == GAP_W'(GAP_CYCLES)) begin
          gap_nxt   = '0;
          done_nxt  = 1'b1;
          len_nxt   = acc;
          state_nxt = S_DONE;
        end else begin
          gap_nxt = gap_inc;
        end
      end

      S_DONE: begin
        gap_nxt = '0;
        if (capture) begin
          acc_nxt   = CNT_WIDTH'(1);
          state_nxt = S_ACTIVE;
        end else begin
          acc_nxt   = '0;
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.port_rd    = rd_issue;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = buf_mem[rd_ptr];
  assign bus.frame_done = frame_done_q;
  assign bus.frame_len  = frame_len_q;
  assign bus.byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_port_drain.sv
// Self-checking bench for port_drain: port FIFO model, byte/frame scoreboards,
// a table of frame vectors and hand-written timing/backpressure/reset sequences.
module tb_port_drain;

  localparam int W   = 8;
  localparam int GAP = 4;
  localparam int CW  = 16;

  typedef struct {
    int nbytes;
    int stall;    // out_ready low one cycle in every `stall` cycles (0: always ready)
    int exp_len;
  } frame_vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  port_drain_if #(.W_WIDTH(W), .CNT_WIDTH(CW)) bus ();

  port_drain #(.W_WIDTH(W), .GAP_CYCLES(GAP), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] fifo [$];
  logic [W-1:0] exp_q [$];
  int           exp_frames [$];
  logic [CW-1:0] exp_bytes = '0;

  int cyc = 0, rd_cnt = 0, done_cnt = 0, pop_cnt = 0;
  int first_rd = -1, first_valid = -1, first_pop = -1;
  int last_rd = -1, last_pop = -1, done_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mark();
    first_rd    = -1;
    first_valid = -1;
    first_pop   = -1;
  endtask

  // One clock: sample at the falling edge, then advance the FIFO model just
  // after the rising edge (port_out valid the cycle after port_rd).
  task automatic step();
    logic        rd_seen;
    logic [63:0] e;
    @(negedge clk);
    rd_seen = bus.port_rd;
    if (rd_seen) begin
      rd_cnt++;
      last_rd = cyc;
      if (first_rd < 0) first_rd = cyc;
    end
    if (bus.out_valid && first_valid < 0) first_valid = cyc;
    if (bus.out_valid && bus.out_ready) begin
      pop_cnt++;
      last_pop = cyc;
      if (first_pop < 0) first_pop = cyc;
      if (exp_q.size() != 0) e = 64'(exp_q.pop_front());
      else e = 'x;
      check("out_data", 64'(bus.out_data), e);
    end
    if (bus.frame_done) begin
      done_cnt++;
      done_cyc = cyc;
      if (exp_frames.size() != 0) e = 64'(exp_frames.pop_front());
      else e = 'x;
      check("frame_len", 64'(bus.frame_len), e);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rd_seen && fifo.size() != 0) bus.port_out = fifo.pop_front();
    bus.port_rdy = (fifo.size() != 0);
  endtask

  task automatic load(input logic [W-1:0] b);
    fifo.push_back(b);
    exp_q.push_back(b);
    bus.port_rdy = 1'b1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int i = 0; i < budget && (done_cnt < target || exp_q.size() != 0); i++) step();
    check("frames_seen", 64'(done_cnt), 64'(target));
    check("bytes_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_vec_t vecs [4];
    int d0, r0, p0, c0;

    vecs = '{'{1, 0, 1}, '{2, 3, 2}, '{7, 2, 7}, '{16, 4, 16}};

    bus.port_rdy  = 1'b0;
    bus.port_out  = '0;
    bus.out_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst_port_rd",    64'(bus.port_rd),    64'd0);
    check("rst_out_valid",  64'(bus.out_valid),  64'd0);
    check("rst_out_data",   64'(bus.out_data),   64'd0);
    check("rst_frame_done", 64'(bus.frame_done), 64'd0);
    check("rst_frame_len",  64'(bus.frame_len),  64'd0);
    check("rst_byte_cnt",   64'(bus.byte_cnt),   64'd0);
    rst_n = 1'b1;
    step();

    // Streaming 0x11..0x15 with out_ready high, then gap timing
    mark();
    r0 = rd_cnt; p0 = pop_cnt; d0 = done_cnt; c0 = cyc;
    for (int i = 0; i < 5; i++) load(W'(8'h11 + i));
    exp_frames.push_back(5);
    exp_bytes += CW'(5);
    for (int i = 0; i < 12; i++) step();
    check("stream_rd_count", 64'(rd_cnt - r0),        64'd5);
    check("stream_first_rd", 64'(first_rd),           64'(c0));
    check("stream_rd_span",  64'(last_rd - first_rd), 64'd4);
    check("stream_latency",  64'(first_valid - first_rd), 64'd2);
    check("stream_pops",     64'(pop_cnt - p0),       64'd5);
    check("stream_pop_span", 64'(last_pop - first_pop), 64'd4);
    check("stream_byte_cnt", 64'(bus.byte_cnt),       64'(exp_bytes));
    wait_frames(d0 + 1, 30);
    // Last read in cycle k, capture in k+1, four idle cycles, pulse in k+6.
    check("gap_timing", 64'(done_cyc - last_rd), 64'(GAP + 2));
    for (int i = 0; i < 3 * GAP; i++) step();
    check("stream_single_done", 64'(done_cnt - d0), 64'd1);

    // Table-driven frames with varying downstream stalls
    for (int v = 0; v < 4; v++) begin
      d0 = done_cnt;
      for (int i = 0; i < vecs[v].nbytes; i++) load(W'($urandom));
      exp_frames.push_back(vecs[v].exp_len);
      exp_bytes += CW'(vecs[v].nbytes);
      for (int i = 0; i < 400 && (exp_q.size() != 0 || done_cnt == d0); i++) begin
        bus.out_ready = (vecs[v].stall == 0) || (cyc % vecs[v].stall != 0);
        step();
      end
      bus.out_ready = 1'b1;
      check("vec_frames",   64'(done_cnt - d0), 64'd1);
      check("vec_drained",  64'(exp_q.size()),  64'd0);
      check("vec_byte_cnt", 64'(bus.byte_cnt),  64'(exp_bytes));
      for (int i = 0; i < 2 * GAP; i++) step();
      check("vec_no_extra_done", 64'(done_cnt - d0), 64'd1);
    end

    // Backpressure: 10 bytes queued with out_ready low
    bus.out_ready = 1'b0;
    r0 = rd_cnt; d0 = done_cnt;
    for (int i = 0; i < 10; i++) load(W'(8'hA0 + i));
    exp_frames.push_back(10);
    exp_bytes += CW'(10);
    for (int i = 0; i < 8; i++) step();
    check("bp_rd_pulses", 64'(rd_cnt - r0),    64'd2);
    check("bp_occ",       64'(dut.occ),        64'd2);
    check("bp_valid",     64'(bus.out_valid),  64'd1);
    check("bp_head",      64'(bus.out_data),   64'hA0);
    check("bp_no_done",   64'(done_cnt - d0),  64'd0);
    bus.out_ready = 1'b1;
    wait_frames(d0 + 1, 80);
    check("bp_byte_cnt", 64'(bus.byte_cnt), 64'(exp_bytes));
    for (int i = 0; i < 2 * GAP; i++) step();
    check("bp_single_done", 64'(done_cnt - d0), 64'd1);

    // Gap boundary: three idle cycles keep one frame
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) load(W'(8'h30 + i));
    exp_frames.push_back(5);
    exp_bytes += CW'(5);
    for (int i = 0; i < 20 && fifo.size() != 0; i++) step();
    for (int i = 0; i < 10 && cyc < last_rd + 5; i++) step();
    for (int i = 0; i < 2; i++) load(W'(8'h40 + i));
    wait_frames(d0 + 1, 40);
    for (int i = 0; i < 2 * GAP; i++) step();
    check("merge_single_done", 64'(done_cnt - d0), 64'd1);

    // Gap boundary: four idle cycles split into two frames
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) load(W'(8'h50 + i));
    exp_frames.push_back(3);
    exp_frames.push_back(2);
    exp_bytes += CW'(5);
    for (int i = 0; i < 20 && fifo.size() != 0; i++) step();
    for (int i = 0; i < 10 && cyc < last_rd + 6; i++) step();
    for (int i = 0; i < 2; i++) load(W'(8'h60 + i));
    wait_frames(d0 + 2, 40);
    for (int i = 0; i < 2 * GAP; i++) step();
    check("split_two_done", 64'(done_cnt - d0), 64'd2);
    check("split_byte_cnt", 64'(bus.byte_cnt),  64'(exp_bytes));

    // Reset mid-frame: 3 bytes captured, read still in flight
    for (int i = 0; i < 5; i++) load(W'(8'h70 + i));
    for (int i = 0; i < 20 && bus.byte_cnt != exp_bytes + CW'(3); i++) step();
    check("pre_rst_byte_cnt", 64'(bus.byte_cnt), 64'(exp_bytes + CW'(3)));
    check("pre_rst_port_rd",  64'(bus.port_rd),  64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_port_rd",    64'(bus.port_rd),    64'd0);
    check("async_rst_out_valid",  64'(bus.out_valid),  64'd0);
    check("async_rst_frame_done", 64'(bus.frame_done), 64'd0);
    check("async_rst_frame_len",  64'(bus.frame_len),  64'd0);
    check("async_rst_byte_cnt",   64'(bus.byte_cnt),   64'd0);
    fifo.delete();
    exp_q.delete();
    exp_bytes    = '0;
    bus.port_rdy = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    d0 = done_cnt;
    for (int i = 0; i < 2; i++) load(W'(8'h80 + i));
    exp_frames.push_back(2);
    exp_bytes += CW'(2);
    wait_frames(d0 + 1, 40);
    for (int i = 0; i < 3 * GAP; i++) step();
    check("post_rst_single_done", 64'(done_cnt - d0), 64'd1);
    check("post_rst_byte_cnt",    64'(bus.byte_cnt),  64'd2);
    check("post_rst_frame_len",   64'(bus.frame_len), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
